wb_ram_arb: RTL

Two-master Wishbone arbiter that shares one `wb_ram` slave port between two requesters. Typical pairing: master 0 is the CPU data bus and master 1 is the framebuffer/DMA reader. It sits between the two masters and the RAM. Arbitration is round-robin, with the grant held for a master's whole `cyc` assertion so that bursts (`cti`/`bte`) stay intact. The block owns grant state only; all addressing and byte-lane handling stays in the RAM.

---
 rtl/wb_ram_arb.sv | 110 +++++++++++
 1 files changed

// File: rtl/wb_ram_arb.sv
// Two-master round-robin Wishbone arbiter in front of a single RAM slave port.
// Ownership is held for the whole cyc of the granted master; every handover passes through IDLE.
module wb_ram_arb #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   gnt0, gnt1;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= ~FIRST_PRIO;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // A tie goes to the master that was not served most recently.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0  = (state_q == GNT0);
  assign gnt1  = (state_q == GNT1);
  assign gnt_o = {gnt1, gnt0};

  // Request fields default to master 0 so they stay deterministic while idle.
  assign s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
  assign s_cti_o = gnt1 ? m1_cti_i : m0_cti_i;
  assign s_bte_o = gnt1 ? m1_bte_i : m0_bte_i;
  assign s_we_o  = (gnt0 & m0_we_i)  | (gnt1 & m1_we_i);
  assign s_cyc_o = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
  assign s_stb_o = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);

  assign m0_ack_o = gnt0 & s_ack_i & m0_cyc_i & m0_stb_i;
  assign m1_ack_o = gnt1 & s_ack_i & m1_cyc_i & m1_stb_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
